// File: rtl/exec_stage_if.sv
// exec_stage_if: instruction issue/retire handshake, status and debug-read
// signals of exec_stage. The master drives instructions; the slave executes them.
interface exec_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        unary;
  logic        imm;
  logic [3:0]  aluop;
  logic        setcc;
  logic [2:0]  rD;
  logic [2:0]  rA;
  logic [2:0]  rB;
  logic [3:0]  immB;
  logic        wben;
  logic        done;
  logic [15:0] result;
  logic [3:0]  flags;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  modport master (
    output in_valid, unary, imm, aluop, setcc, rD, rA, rB, immB, wben, dbg_sel,
    input  in_ready, done, result, flags, dbg_data
  );

  modport slave (
    input  in_valid, unary, imm, aluop, setcc, rD, rA, rB, immB, wben, dbg_sel,
    output in_ready, done, result, flags, dbg_data
  );
endinterface

// File: rtl/exec_stage.sv
// exec_stage: 8x16 register file with a single-issue ALU. MULT runs a 16-cycle
// shift-add sequence; every other op retires the cycle after issue.
module exec_stage (
  input  logic         clk,
  input  logic         reset_n,
  exec_stage_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RETIRE} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0001, OP_SUB  = 4'b0010, OP_SHL = 4'b0101, OP_SHAR = 4'b0110,
    OP_SHLR = 4'b0111, OP_RL   = 4'b1000, OP_RR  = 4'b1001, OP_AND  = 4'b1011,
    OP_OR   = 4'b1100, OP_XOR  = 4'b1101, OP_NOT = 4'b1110, OP_MULT = 4'b1111
  } op_e;

  state_e      state_q, state_d;
  logic [15:0] regs_q [8];
  logic [15:0] result_q;
  logic [3:0]  flags_q;

  logic [31:0] mcand_q, acc_q;
  logic [15:0] mplier_q;
  logic [3:0]  cnt_q;
  logic [2:0]  mrd_q;
  logic        mwben_q, msetcc_q;

  logic [15:0] op_a, op_b;
  logic [3:0]  amt;
  logic        hs, is_mult;
  logic [16:0] sum, shl_t, shr_t, sar_t;
  logic [15:0] rl_t, rr_t;
  logic [15:0] alu_res;
  logic        alu_c, alu_v, alu_ok;
  logic [31:0] acc_next;

  logic        wr_en, fl_en, res_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  fl_data;

  assign op_a     = regs_q[bus.rA];
  assign op_b     = bus.imm ? {12'b0, bus.immB} : regs_q[bus.rB];
  assign amt      = op_b[3:0];
  assign hs       = bus.in_valid && (state_q == S_IDLE);
  assign is_mult  = !bus.unary && (bus.aluop == OP_MULT);
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Shifters carry one extra bit so the last bit shifted out lands in a fixed
  // position; with amt==0 that bit is always 0.
  assign shl_t = {1'b0, op_a} << amt;
  assign shr_t = {op_a, 1'b0} >> amt;
  assign sar_t = $signed({op_a, 1'b0}) >>> amt;
  assign rl_t  = (op_a << amt) | (op_a >> (5'd16 - {1'b0, amt}));
  assign rr_t  = (op_a >> amt) | (op_a << (5'd16 - {1'b0, amt}));

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    if (bus.unary) begin
      alu_res = op_b;
    end else begin
      case (bus.aluop)
        OP_ADD: begin
          sum     = {1'b0, op_a} + {1'b0, op_b};
          alu_res = sum[15:0];
          alu_c   = sum[16];
          alu_v   = (op_a[15] == op_b[15]) && (sum[15] != op_a[15]);
        end
        OP_SUB: begin
          sum     = {1'b0, op_a} - {1'b0, op_b};
          alu_res = sum[15:0];
          alu_c   = sum[16];
          alu_v   = (op_a[15] != op_b[15]) && (sum[15] != op_a[15]);
        end
        OP_SHL:  begin alu_res = shl_t[15:0];  alu_c = shl_t[16]; end
        OP_SHAR: begin alu_res = sar_t[16:1];  alu_c = sar_t[0];  end
        OP_SHLR: begin alu_res = shr_t[16:1];  alu_c = shr_t[0];  end
        OP_RL:   begin alu_res = rl_t; alu_c = (amt != 4'd0) && rl_t[0];  end
        OP_RR:   begin alu_res = rr_t; alu_c = (amt != 4'd0) && rr_t[15]; end
        OP_AND:  alu_res = op_a & op_b;
        OP_OR:   alu_res = op_a | op_b;
        OP_XOR:  alu_res = op_a ^ op_b;
        OP_NOT:  alu_res = ~op_a;
        OP_MULT: alu_res = '0;
        default: alu_ok  = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    fl_en   = 1'b0;
    res_en  = 1'b0;
    wr_addr = bus.rD;
    wr_data = alu_res;
    fl_data = {alu_res == 16'd0, alu_res[15], alu_c, alu_v};
    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (is_mult) begin
            state_d = S_MUL;
          end else begin
            state_d = S_RETIRE;
            wr_en   = bus.wben && alu_ok;
            fl_en   = bus.setcc && alu_ok;
            res_en  = alu_ok;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == 4'd15) begin
          state_d = S_RETIRE;
          wr_en   = mwben_q;
          fl_en   = msetcc_q;
          res_en  = 1'b1;
          wr_addr = mrd_q;
          wr_data = acc_next[15:0];
          fl_data = {acc_next[15:0] == 16'd0, acc_next[15],
                     |acc_next[31:16], |acc_next[31:16]};
        end
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mrd_q    <= '0;
      mwben_q  <= 1'b0;
      msetcc_q <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) regs_q[i[2:0]] <= '0;
    end else begin
      state_q <= state_d;
      if (wr_en)  regs_q[wr_addr] <= wr_data;
      if (fl_en)  flags_q <= fl_data;
      if (res_en) result_q <= wr_data;
      // Operands are captured at issue so a later register write cannot disturb the product.
      if (hs && is_mult) begin
        mcand_q  <= {16'b0, op_a};
        mplier_q <= op_b;
        acc_q    <= '0;
        cnt_q    <= '0;
        mrd_q    <= bus.rD;
        mwben_q  <= bus.wben;
        msetcc_q <= bus.setcc;
      end else if (state_q == S_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 4'd1;
      end
    end
  end

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.done     = (state_q == S_RETIRE);
  assign bus.result   = result_q;
  assign bus.flags    = flags_q;
  assign bus.dbg_data = regs_q[bus.dbg_sel];
endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port list (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  block can accept an instruction this cycle
- unary  input  1  operand A ignored; result = operand B (MOV/MOVI)
- imm  input  1  operand B = zero-extended immB, else R[rB]
- aluop  input  4  ALU operation code
- setcc  input  1  update flags from this result
- rD, rA, rB  input  3 each  destination / source register indices
- immB  input  4  immediate field
- wben  input  1  write result to R[rD]
- done  output  1  one-cycle pulse: instruction retired
- result  output  16  last computed result, held until next retire
- flags  output  4  {Z,N,C,V}
- dbg_sel  input  3  debug register select
- dbg_data  output  16  R[dbg_sel], combinational

Function
REQ-003 The block SHALL contain eight 16-bit registers R0..R7, read asynchronously and written on clk rising edge.
REQ-004 Operand A = R[rA]; operand B = imm ? {12'b0, immB} : R[rB]; a handshake SHALL occur when in_valid and in_ready are both 1.
REQ-005 aluop encodings: 0001 ADD, 0010 SUB, 0101 SHL, 0110 SHAR, 0111 SHLR, 1000 RL, 1001 RR, 1011 AND, 1100 OR, 1101 XOR, 1110 NOT (~A), 1111 MULT; any other code SHALL be treated as a no-op (no write, no flag change, done still pulses).
REQ-006 unary=1 SHALL force result = operand B regardless of aluop.
REQ-007 Shift/rotate amount SHALL be B[3:0]; amount 0 returns A unchanged.
REQ-008 States: IDLE, MUL, RETIRE; in_ready = 1 only in IDLE.
REQ-009 IDLE, handshake, non-MULT op: result computed combinationally, R[rD] written (if wben) and flags updated (if setcc) on that edge; next state RETIRE.
REQ-010 IDLE, handshake, MULT: operands latched, next state MUL; shift-add multiplier iterates exactly 16 cycles in MUL, then writes low 16 bits of product and goes to RETIRE (handshake-to-done latency 17 cycles).
REQ-011 RETIRE SHALL assert done for exactly one cycle and return to IDLE (single-cycle op latency: done one cycle after handshake; throughput one instruction per 2 cycles).
REQ-012 in_valid while in_ready=0 SHALL be ignored; upstream holds the instruction.
REQ-013 Flags when setcc=1: Z = (result==0); N = result[15]; ADD: C = carry out, V = signed overflow; SUB: C = borrow (A<B unsigned), V = signed overflow; shifts/rotates: C = last bit shifted/rotated out (0 for amount 0), V = 0; AND/OR/XOR/NOT/MOV: C = 0, V = 0; MULT: C = V = (product[31:16] != 0).
REQ-014 Flags with setcc=0 SHALL hold their previous value.
REQ-015 Writing with rD == rA or rB SHALL use pre-write operand values (multiply uses latched copies).
REQ-016 dbg_data SHALL reflect a write from the cycle after the write edge.

Reset
REQ-017 reset_n low SHALL immediately clear R0..R7, result, flags to 0, done to 0, and state to IDLE.
REQ-018 Reset during MUL SHALL abort the multiply with no register write and no done pulse.

Verification
REQ-019 Reset, then ADDI rD=1 rA=0 immB=5 setcc=1 -> done one cycle later, R1=0x0005, flags=0000.
REQ-020 R1=0x7FFF, ADD rD=2 rA=1 rB=1(reg=R1 via MOV) setcc=1 -> R2=0xFFFE, flags N=1, V=1, C=0, Z=0.
REQ-021 R3=0x0100, R4=0x0100, MULT rD=5 setcc=1 -> in_ready low 17 cycles, done at handshake+17, R5=0x0000, flags Z=1, C=1, V=1.
REQ-022 R6=0x8001, RLI rD=6 rA=6 immB=1 setcc=1 -> R6=0x0003, C=1; then SHARI immB=0 -> R6 unchanged, C=0.
REQ-023 Assert reset_n low 5 cycles into a MULT -> no done, all registers 0, in_ready=1 after release.
REQ-024 aluop=0011 with wben=1 setcc=1 -> done pulses, no register or flag change; SUBI with setcc=0 -> flags unchanged.
